dwc_lpddr5xphy_pclk_rpt_array: RTL and testbench

// - Multi-lane, parametrised successor to the single-bit PclkOut repeater cell.
// - Retimes NUM_CH lanes of WIDTH-bit Pclk-domain signals through a DEPTH-stage

---
 rtl/dwc_lpddr5xphy_pclk_rpt_array.sv | 123 ++++++++++++
 tb/tb_dwc_lpddr5xphy_pclk_rpt_array.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dwc_lpddr5xphy_pclk_rpt_array.sv
// rtl/dwc_lpddr5xphy_pclk_rpt_array.sv - multi-lane Pclk repeater array with power-good sequencer
// Lanes are retimed through DEPTH flops and held at zero until power has settled and the pipe has flushed.
module dwc_lpddr5xphy_pclk_rpt_array #(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 2,
  parameter int DEPTH         = 3,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                    Pclk,
  input  logic                    Reset,
  input  logic                    PwrOk,
  input  logic [NUM_CH-1:0]       LaneEn,
  input  logic [NUM_CH*WIDTH-1:0] DataIn,
  output logic [NUM_CH*WIDTH-1:0] DataOut,
  output logic                    Ready,
  output logic [1:0]              State,
  output logic [NUM_CH-1:0]       LaneActive
);

  localparam int NW          = NUM_CH * WIDTH;
  localparam int CNT_MAX     = (SETTLE_CYCLES > DEPTH) ? SETTLE_CYCLES : DEPTH;
  localparam int CW          = $clog2(CNT_MAX + 1);
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int FLUSH_LAST  = DEPTH - 1;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_FLUSH  = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [DEPTH-1:0][NW-1:0] pipe;
  logic [NUM_CH-1:0]        lane_en_q;
  logic                     pipe_run;

  always_ff @(posedge Pclk) begin
    if (Reset) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One counter serves both phases: counts up through SETTLE, down through FLUSH.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!PwrOk) begin
      state_n = S_OFF;
      cnt_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (SETTLE_CYCLES == 0) begin
            state_n = S_FLUSH;
            cnt_n   = CW'(FLUSH_LAST);
          end else begin
            state_n = S_SETTLE;
            cnt_n   = '0;
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_LAST)) begin
            state_n = S_FLUSH;
            cnt_n   = CW'(FLUSH_LAST);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          if (cnt == '0) begin
            state_n = S_ACTIVE;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_ACTIVE: begin
          cnt_n = '0;
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign pipe_run = PwrOk && ((state == S_FLUSH) || (state == S_ACTIVE));

  always_ff @(posedge Pclk) begin
    if (Reset || !pipe_run) begin
      pipe <= '0;
    end else begin
      pipe[0] <= DataIn;
      for (int n = 1; n < DEPTH; n++) begin
        pipe[n] <= pipe[n-1];
      end
    end
  end

  always_ff @(posedge Pclk) begin
    if (Reset) begin
      lane_en_q <= '0;
    end else begin
      lane_en_q <= LaneEn;
    end
  end

  assign Ready      = (state == S_ACTIVE);
  assign State      = state;
  assign LaneActive = {NUM_CH{Ready}} & lane_en_q;

  // Output gating is a pure AND of flop outputs, so Ready edges cannot glitch lanes.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign DataOut[i*WIDTH +: WIDTH] = pipe[DEPTH-1][i*WIDTH +: WIDTH] & {WIDTH{LaneActive[i]}};
  end

endmodule

// File: tb/tb_dwc_lpddr5xphy_pclk_rpt_array.sv
// tb/tb_dwc_lpddr5xphy_pclk_rpt_array.sv - scoreboard bench for the Pclk repeater array
// Expected per-cycle outputs are queued as stimulus is applied and popped after each edge.
module tb_dwc_lpddr5xphy_pclk_rpt_array;

  typedef struct packed {
    logic [1:0] st;
    logic       rdy;
    logic [7:0] dout;
    logic [3:0] la;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic       PwrOk, PwrOk1;
  logic [3:0] LaneEn, LaneEn1;
  logic [7:0] DataIn, DataIn1;
  logic [7:0] DataOut, DataOut1;
  logic       Ready, Ready1;
  logic [1:0] State, State1;
  logic [3:0] LaneActive, LaneActive1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t e, obs;

  always #5 clk = ~clk;

  dwc_lpddr5xphy_pclk_rpt_array #(
    .NUM_CH(4), .WIDTH(2), .DEPTH(3), .SETTLE_CYCLES(8)
  ) u0 (
    .Pclk(clk), .Reset(Reset), .PwrOk(PwrOk), .LaneEn(LaneEn), .DataIn(DataIn),
    .DataOut(DataOut), .Ready(Ready), .State(State), .LaneActive(LaneActive)
  );

  dwc_lpddr5xphy_pclk_rpt_array #(
    .NUM_CH(4), .WIDTH(2), .DEPTH(1), .SETTLE_CYCLES(0)
  ) u1 (
    .Pclk(clk), .Reset(Reset), .PwrOk(PwrOk1), .LaneEn(LaneEn1), .DataIn(DataIn1),
    .DataOut(DataOut1), .Ready(Ready1), .State(State1), .LaneActive(LaneActive1)
  );

  task automatic push_n(input int n, input logic [1:0] st, input logic rdy,
                        input logic [7:0] dout, input logic [3:0] la);
    for (int i = 0; i < n; i++) sb.push_back({st, rdy, dout, la});
  endtask

  task automatic test_reset();
    Reset = 1'b1; PwrOk = 1'b1; DataIn = 8'hFF; LaneEn = 4'hF;
    PwrOk1 = 1'b1; DataIn1 = 8'hFF; LaneEn1 = 4'hF;
    push_n(2, 2'd0, 1'b0, 8'h00, 4'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got st=%0d rdy=%b dout=%h la=%h want st=%0d rdy=%b dout=%h la=%h",
                 i, obs.st, obs.rdy, obs.dout, obs.la, e.st, e.rdy, e.dout, e.la);
      end
    end
    Reset = 1'b0; PwrOk = 1'b0; PwrOk1 = 1'b0;
    push_n(1, 2'd0, 1'b0, 8'h00, 4'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_release got st=%0d rdy=%b dout=%h la=%h want st=%0d rdy=%b dout=%h la=%h",
               obs.st, obs.rdy, obs.dout, obs.la, e.st, e.rdy, e.dout, e.la);
    end
  endtask

  task automatic test_power_up();
    PwrOk = 1'b1; DataIn = 8'hA5; LaneEn = 4'hF;
    push_n(8, 2'd1, 1'b0, 8'h00, 4'h0);
    push_n(3, 2'd2, 1'b0, 8'h00, 4'h0);
    push_n(2, 2'd3, 1'b1, 8'hA5, 4'hF);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL power_up cyc=%0d got st=%0d rdy=%b dout=%h la=%h want st=%0d rdy=%b dout=%h la=%h",
                 i, obs.st, obs.rdy, obs.dout, obs.la, e.st, e.rdy, e.dout, e.la);
      end
    end
  endtask

  task automatic test_latency();
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        DataIn = 8'h00;
        push_n(2, 2'd3, 1'b1, 8'hA5, 4'hF);
        push_n(2, 2'd3, 1'b1, 8'h00, 4'hF);
      end else begin
        DataIn = 8'h3C;
        push_n(2, 2'd3, 1'b1, 8'h00, 4'hF);
        push_n(2, 2'd3, 1'b1, 8'h3C, 4'hF);
      end
      for (int i = 0; sb.size() > 0; i++) begin
        @(posedge clk); #1;
        e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL latency ph=%0d cyc=%0d got dout=%h rdy=%b want dout=%h rdy=%b",
                   ph, i, obs.dout, obs.rdy, e.dout, e.rdy);
        end
      end
    end
  endtask

  task automatic test_lane_gating();
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 0) begin
        DataIn = 8'hFF;
        push_n(2, 2'd3, 1'b1, 8'h3C, 4'hF);
        push_n(1, 2'd3, 1'b1, 8'hFF, 4'hF);
      end else if (ph == 1) begin
        LaneEn = 4'h5;
        push_n(2, 2'd3, 1'b1, 8'h33, 4'h5);
      end else begin
        LaneEn = 4'hA;
        push_n(1, 2'd3, 1'b1, 8'hCC, 4'hA);
      end
      for (int i = 0; sb.size() > 0; i++) begin
        @(posedge clk); #1;
        e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL lane_gate ph=%0d cyc=%0d got dout=%h la=%h want dout=%h la=%h",
                   ph, i, obs.dout, obs.la, e.dout, e.la);
        end
      end
    end
    LaneEn = 4'hF;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_abort();
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin PwrOk = 1'b0; push_n(1, 2'd0, 1'b0, 8'h00, 4'h0); end
        1: begin
          PwrOk = 1'b1; DataIn = 8'hC3;
          push_n(8, 2'd1, 1'b0, 8'h00, 4'h0);
          push_n(1, 2'd2, 1'b0, 8'h00, 4'h0);
        end
        2: begin PwrOk = 1'b0; push_n(1, 2'd0, 1'b0, 8'h00, 4'h0); end
        default: begin
          PwrOk = 1'b1;
          push_n(8, 2'd1, 1'b0, 8'h00, 4'h0);
          push_n(3, 2'd2, 1'b0, 8'h00, 4'h0);
          push_n(2, 2'd3, 1'b1, 8'hC3, 4'hF);
        end
      endcase
      for (int i = 0; sb.size() > 0; i++) begin
        @(posedge clk); #1;
        e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL flush_abort ph=%0d cyc=%0d got st=%0d rdy=%b dout=%h want st=%0d rdy=%b dout=%h",
                   ph, i, obs.st, obs.rdy, obs.dout, e.st, e.rdy, e.dout);
        end
      end
    end
  endtask

  task automatic test_toggle();
    PwrOk = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      PwrOk = (i % 2 == 0);
      push_n(1, PwrOk ? 2'd1 : 2'd0, 1'b0, 8'h00, 4'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {State, Ready, DataOut, LaneActive}; total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL toggle cyc=%0d got st=%0d rdy=%b want st=%0d rdy=%b",
                 i, obs.st, obs.rdy, e.st, e.rdy);
      end
    end
  endtask

  task automatic test_no_settle();
    DataIn1 = 8'h5A; LaneEn1 = 4'hF; PwrOk1 = 1'b1;
    push_n(1, 2'd2, 1'b0, 8'h00, 4'h0);
    push_n(2, 2'd3, 1'b1, 8'h5A, 4'hF);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        PwrOk1 = 1'b0;
        push_n(1, 2'd0, 1'b0, 8'h00, 4'h0);
      end
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {State1, Ready1, DataOut1, LaneActive1}; total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL no_settle cyc=%0d got st=%0d rdy=%b dout=%h la=%h want st=%0d rdy=%b dout=%h la=%h",
                 i, obs.st, obs.rdy, obs.dout, obs.la, e.st, e.rdy, e.dout, e.la);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_latency();
    test_lane_gating();
    test_flush_abort();
    test_toggle();
    test_no_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
